// File: rtl/encoder9_merge_if.sv
// Flit bundle for the 2-to-1 merge: two input flit channels, the merged
// flit channel and the select-token channel naming each flit's source.
interface encoder9_merge_if #(
    parameter int W = 9
);
    logic [W-1:0] In0_data;
    logic         In0_valid;
    logic         In0_ready;
    logic [W-1:0] In1_data;
    logic         In1_valid;
    logic         In1_ready;
    logic [W-1:0] Out_data;
    logic         Out_valid;
    logic         Out_ready;
    logic         S_data;
    logic         S_valid;
    logic         S_ready;

    // Environment side: offers flits and consumes the merged and select tokens.
    modport master (
        output In0_data, In0_valid, In1_data, In1_valid, Out_ready, S_ready,
        input  In0_ready, In1_ready, Out_data, Out_valid, S_data, S_valid
    );

    // Merge side.
    modport slave (
        input  In0_data, In0_valid, In1_data, In1_valid, Out_ready, S_ready,
        output In0_ready, In1_ready, Out_data, Out_valid, S_data, S_valid
    );
endinterface

// File: rtl/encoder9_merge.sv
// Two-source flit merge with packet locking. Each accepted flit becomes one
// Out token plus one S token carrying its source index.
module encoder9_merge #(
    parameter int W = 9
) (
    input  logic             CLK,
    input  logic             RESET,
    encoder9_merge_if.slave  bus
);

    logic [W-1:0] out_data_q;
    logic         out_valid_q;
    logic         s_data_q;
    logic         s_valid_q;
    logic         lock_q;
    logic         lock_src_q;
    logic         last_src_q;

    logic         avail;
    logic         grant;
    logic         acc0;
    logic         acc1;
    logic         accept;
    logic [W-1:0] flit;

    // A new flit may only enter when both output registers are free or draining.
    assign avail = (!out_valid_q || bus.Out_ready) && (!s_valid_q || bus.S_ready);

    // Lock wins; otherwise a lone requester, else alternate away from the last source.
    always_comb begin
        grant = ~last_src_q;
        if (lock_q) begin
            grant = lock_src_q;
        end else if (bus.In0_valid && !bus.In1_valid) begin
            grant = 1'b0;
        end else if (bus.In1_valid && !bus.In0_valid) begin
            grant = 1'b1;
        end
    end

    assign bus.In0_ready = !RESET && avail && (grant == 1'b0);
    assign bus.In1_ready = !RESET && avail && (grant == 1'b1);

    assign acc0   = bus.In0_valid && bus.In0_ready;
    assign acc1   = bus.In1_valid && bus.In1_ready;
    assign accept = acc0 || acc1;
    assign flit   = acc1 ? bus.In1_data : bus.In0_data;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            s_data_q    <= 1'b0;
            s_valid_q   <= 1'b0;
            lock_q      <= 1'b0;
            lock_src_q  <= 1'b0;
            last_src_q  <= 1'b1;
        end else if (accept) begin
            out_data_q  <= flit;
            out_valid_q <= 1'b1;
            s_data_q    <= acc1;
            s_valid_q   <= 1'b1;
            lock_q      <= ~flit[W-1];
            lock_src_q  <= acc1;
            last_src_q  <= acc1;
        end else begin
            if (bus.Out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bus.S_ready) begin
                s_valid_q <= 1'b0;
            end
        end
    end

    assign bus.Out_data  = out_data_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.S_data    = s_data_q;
    assign bus.S_valid   = s_valid_q;

endmodule

// File: doc/encoder9_merge.md
ENCODER9_MERGE -- requirements
Module: encoder9_merge

Interface
REQ-001 Parameter W, default 9, flit width in bits; bit W-1 is the tail flag, bits W-2..0 payload.
REQ-002 Port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port RESET, input, 1, synchronous active-high reset.
REQ-004 Ports In0_data / In1_data, input, W, flit offered by source 0 / 1.
REQ-005 Ports In0_valid / In1_valid, input, 1, source 0 / 1 offers a flit.
REQ-006 Ports In0_ready / In1_ready, output, 1, merge accepts source 0 / 1 flit this cycle.
REQ-007 Ports Out_data, output, W; Out_valid, output, 1; Out_ready, input, 1: merged flit channel.
REQ-008 Ports S_data, output, 1; S_valid, output, 1; S_ready, input, 1: select token, the source index of each flit on Out.

Function
REQ-009 A transfer on any channel SHALL occur exactly on a rising edge where its valid and ready are both 1.
REQ-010 The block SHALL be the inverse of the 2-way flit decoder: each accepted input flit produces exactly one Out token plus one S token carrying its source index (0 or 1).
REQ-011 Out and S SHALL each be a 1-deep output register with its own valid bit, drained independently by its own ready.
REQ-012 Output availability avail = (!Out_valid | Out_ready) & (!S_valid | S_ready), combinational.
REQ-013 At most one of In0_ready/In1_ready SHALL be 1 in any cycle; InX_ready = avail & grant==X & InX_valid-independent (ready does not depend on InX_valid).
REQ-014 Grant selection when unlocked: only one valid -> that source; both valid -> source != last_src (round-robin); neither valid -> grant = !last_src.
REQ-015 When locked, grant SHALL be lock_src regardless of the other source's valid.
REQ-016 On an accepted flit with tail=0, the block SHALL set lock=1, lock_src=source; on an accepted flit with tail=1, lock=0.
REQ-017 On every accepted flit, last_src SHALL update to its source index.
REQ-018 On acceptance, Out_data<=flit, Out_valid<=1, S_data<=source, S_valid<=1 in the same edge; latency input->output is one cycle.
REQ-019 A register whose token is taken with no new acceptance that edge SHALL clear its valid; simultaneous drain and accept SHALL reload (valid stays 1), giving one flit per cycle sustained.
REQ-020 If only one of Out/S drains, the other SHALL hold its valid and data; no new flit is accepted until both are available.
REQ-021 Out_data and S_data SHALL be stable while their valid is 1 and ready is 0.
REQ-022 A locked source deasserting valid mid-packet SHALL stall the merge; the other source SHALL NOT be granted until the tail transfers.

Reset
REQ-023 While RESET=1 at an edge: Out_valid=0, S_valid=0, Out_data=0, S_data=0, lock=0, lock_src=0, last_src=1.
REQ-024 In0_ready and In1_ready SHALL be 0 during any cycle RESET=1; flits held in output registers SHALL be discarded.
REQ-025 Reset mid-packet SHALL clear the lock; first grant after reset with both valid SHALL be source 0.

Verification
REQ-026 Single flit: In0 offers 0x1A5 (tail=1), Out_ready=S_ready=1 -> next cycle Out_data=0x1A5, S_data=0, both valid one cycle.
REQ-027 Contention: both offer tail flits continuously, all readies 1 -> S sequence 0,1,0,1..., one flit per cycle, none lost.
REQ-028 Packet lock: In1 sends 0x003,0x004 (tail=0) then 0x105 (tail=1) while In0 valid throughout -> S=1,1,1 then 0; no In0 flit interleaved.
REQ-029 Split backpressure: Out_ready=1, S_ready=0 for 3 cycles after one accept -> Out_valid drops, S_valid holds S_data, InX_ready=0 until S drains.
REQ-030 Reset mid-packet: assert RESET after a tail=0 flit from In1 -> outputs valid=0; then both valid -> source 0 granted first.
REQ-031 Scoreboard: random valids/readies, 10k cycles -> per-source order preserved, Out/S token counts equal, packets never interleaved.
